// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer: drives register-file selects, owns SP arithmetic
// and moves bytes over a req/ack memory handshake.
module stack_sequencer #(
    parameter int unsigned WZ_SEL = 0,
    parameter int unsigned SP_SEL = 4,
    parameter int unsigned PC_SEL = 5
) (
    input  logic        i_Clk,
    input  logic        i_nRst,
    input  logic        i_Enable,
    input  logic        i_Start,
    input  logic [1:0]  i_Op,
    input  logic [1:0]  i_Pair,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [5:0]  o_Read16,
    output logic [5:0]  o_Write16,
    output logic [15:0] o_Bus16,
    input  logic [15:0] i_Bus16,
    output logic        o_Mem_Req,
    output logic        o_Mem_We,
    output logic [15:0] o_Mem_Addr,
    output logic [7:0]  o_Mem_Wdata,
    input  logic        i_Mem_Ack,
    input  logic [7:0]  i_Mem_Rdata
);

    typedef enum logic [3:0] {
        StIdle,
        StLdSrc,
        StLdSp,
        StMemHi,
        StMemLo,
        StWbSp,
        StWbDst,
        StJmp,
        StDone
    } state_e;

    localparam logic [1:0] OpPush = 2'd0;
    localparam logic [1:0] OpCall = 2'd2;
    localparam logic [1:0] OpRet  = 2'd3;

    localparam logic [5:0] WzOh = 6'(1) << WZ_SEL;
    localparam logic [5:0] SpOh = 6'(1) << SP_SEL;
    localparam logic [5:0] PcOh = 6'(1) << PC_SEL;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  pair_q, pair_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] data_q, data_d;

    logic [5:0]  write_sel;
    logic [5:0]  pair_oh;
    logic        write_dir;
    logic        xfer;

    // Pair index doubles as its select bit (WZ=0, BC=1, DE=2, HL=3).
    assign pair_oh   = 6'(1) << pair_q;
    // POP and RET have odd opcodes and read from memory; PUSH and CALL write.
    assign write_dir = ~op_q[0];
    assign xfer      = i_Enable & i_Mem_Ack;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pair_d      = pair_q;
        sp_d        = sp_q;
        data_d      = data_q;
        o_Done      = 1'b0;
        o_Read16    = '0;
        write_sel   = '0;
        o_Bus16     = '0;
        o_Mem_Req   = 1'b0;
        o_Mem_We    = 1'b0;
        o_Mem_Addr  = '0;
        o_Mem_Wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (i_Start) begin
                    op_d    = i_Op;
                    pair_d  = i_Pair;
                    state_d = i_Op[0] ? StLdSp : StLdSrc;
                end
            end
            StLdSrc: begin
                o_Read16 = (op_q == OpCall) ? PcOh : pair_oh;
                data_d   = i_Bus16;
                state_d  = StLdSp;
            end
            StLdSp: begin
                o_Read16 = SpOh;
                if (write_dir) begin
                    sp_d    = i_Bus16 - 16'd1;
                    state_d = StMemHi;
                end else begin
                    sp_d    = i_Bus16;
                    state_d = StMemLo;
                end
            end
            StMemHi: begin
                o_Mem_Req  = 1'b1;
                o_Mem_Addr = sp_q;
                if (write_dir) begin
                    o_Mem_We    = 1'b1;
                    o_Mem_Wdata = data_q[15:8];
                    if (xfer) begin
                        sp_d    = sp_q - 16'd1;
                        state_d = StMemLo;
                    end
                end else if (xfer) begin
                    data_d[15:8] = i_Mem_Rdata;
                    sp_d         = sp_q + 16'd1;
                    state_d      = StWbSp;
                end
            end
            StMemLo: begin
                o_Mem_Req  = 1'b1;
                o_Mem_Addr = sp_q;
                if (write_dir) begin
                    o_Mem_We    = 1'b1;
                    o_Mem_Wdata = data_q[7:0];
                    if (xfer) begin
                        state_d = StWbSp;
                    end
                end else if (xfer) begin
                    data_d[7:0] = i_Mem_Rdata;
                    sp_d        = sp_q + 16'd1;
                    state_d     = StMemHi;
                end
            end
            StWbSp: begin
                write_sel = SpOh;
                o_Bus16   = sp_q;
                if (op_q == OpPush) begin
                    state_d = StDone;
                end else if (op_q == OpCall) begin
                    state_d = StJmp;
                end else begin
                    state_d = StWbDst;
                end
            end
            StWbDst: begin
                write_sel = (op_q == OpRet) ? PcOh : pair_oh;
                o_Bus16   = data_q;
                state_d   = StDone;
            end
            StJmp: begin
                o_Read16  = WzOh;
                write_sel = PcOh;
                o_Bus16   = i_Bus16;
                state_d   = StDone;
            end
            StDone: begin
                o_Done  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_Busy    = (state_q != StIdle);
    // A disabled tick must not commit a register-file write.
    assign o_Write16 = i_Enable ? write_sel : 6'd0;

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q <= StIdle;
            op_q    <= '0;
            pair_q  <= '0;
            sp_q    <= '0;
            data_q  <= '0;
        end else if (i_Enable) begin
            state_q <= state_d;
            op_q    <= op_d;
            pair_q  <= pair_d;
            sp_q    <= sp_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Multi-cycle controller for the CPU register file that executes PUSH rr, POP rr, CALL and RET. It drives the register file's one-hot 16-bit read/write selects and write bus, owns SP arithmetic, and performs byte transfers over a req/ack memory handshake. It sits between instruction decode, which issues commands, and the register file and memory arbiter.

Parameters:
WZ_SEL, 0, bit index of WZ in the 16-bit select vectors
SP_SEL, 4, bit index of SP in the 16-bit select vectors
PC_SEL, 5, bit index of PC in the 16-bit select vectors

Ports:
i_Clk  in  1  system clock
i_nRst  in  1  asynchronous active-low reset
i_Enable  in  1  tick enable; when low, state and data registers hold
i_Start  in  1  command strobe; sampled only in IDLE
i_Op  in  2  0=PUSH, 1=POP, 2=CALL, 3=RET
i_Pair  in  2  register pair for PUSH/POP: 0=WZ, 1=BC, 2=DE, 3=HL
o_Busy  out  1  high whenever state != IDLE
o_Done  out  1  one-cycle pulse in DONE
o_Read16  out  6  one-hot register-file read select, zero otherwise
o_Write16  out  6  one-hot register-file write select, zero otherwise
o_Bus16  out  16  register-file write data
i_Bus16  in  16  register-file read data (combinational)
o_Mem_Req  out  1  memory request
o_Mem_We  out  1  1=write, 0=read
o_Mem_Addr  out  16  byte address (= r_SP)
o_Mem_Wdata  out  8  write byte
i_Mem_Ack  in  1  memory acknowledge
i_Mem_Rdata  in  8  read byte, valid with ack

Behaviour:
- Reset (async, i_nRst=0): state=IDLE; r_Op, r_Pair, r_SP, r_Data=0. All outputs are 0. A reset mid-operation aborts the command with no further register writes.
- Moore outputs are decoded from state. o_Write16 is additionally gated by i_Enable. With i_Enable=0, nothing advances and i_Mem_Ack is ignored.
- IDLE: if i_Start, latch i_Op and i_Pair. PUSH/CALL go to LD_SRC. POP/RET go to LD_SP.
- LD_SRC: o_Read16 selects pair (PUSH) or PC (CALL); r_Data<=i_Bus16. Next state is LD_SP.
- LD_SP: o_Read16[SP_SEL]=1.
  - PUSH/CALL: r_SP<=i_Bus16-1, next MEM_HI.
  - POP/RET: r_SP<=i_Bus16, next MEM_LO.
- Memory states: o_Mem_Req=1 and o_Mem_Addr=r_SP. A transfer completes on the first edge with i_Enable & i_Mem_Ack. Until then, Req, We, Addr and Wdata stay stable. Zero-wait ack (same cycle as Req) is legal.
- MEM_HI:
  - Write direction: We=1, Wdata=r_Data[15:8]; on ack r_SP<=r_SP-1, next MEM_LO.
  - Read direction: We=0; on ack r_Data[15:8]<=i_Mem_Rdata, r_SP<=r_SP+1, next WB_SP.
- MEM_LO:
  - Write direction: We=1, Wdata=r_Data[7:0]; on ack (no SP change) next WB_SP.
  - Read direction: We=0; on ack r_Data[7:0]<=i_Mem_Rdata, r_SP<=r_SP+1, next MEM_HI.
- WB_SP: o_Write16[SP_SEL]=1, o_Bus16=r_SP. Next state:
  - PUSH: DONE.
  - CALL: JMP.
  - POP/RET: WB_DST.
- WB_DST: o_Write16 selects pair (POP) or PC (RET); o_Bus16=r_Data. Next DONE.
- JMP (CALL only): o_Read16[WZ_SEL]=1, o_Write16[PC_SEL]=1, o_Bus16=i_Bus16 (pass-through). Next DONE.
- DONE: o_Done=1, o_Busy=1. Next IDLE. A start asserted in DONE or any busy state is ignored, not queued.
- SP arithmetic is 16-bit modulo:
  - PUSH with SP=0x0000 writes 0xFFFF then 0xFFFE; final SP=0xFFFE.
  - POP with SP=0xFFFF reads 0xFFFF then 0x0000; final SP=0x0001.
- At most one bit of o_Read16 and o_Write16 is set in any cycle.
- Latency with zero-wait memory, counting from the edge that accepts i_Start to o_Done high: PUSH 6 cycles, POP/RET 6, CALL 7. Each memory wait cycle adds 1.

Test Plan:
- PUSH BC, BC=0x1234, SP=0xFFFE, zero-wait ack -> write 0x12 @0xFFFD, then 0x34 @0xFFFC; SP=0xFFFC; o_Done in cycle 6.
- POP DE, SP=0xFFFC, memory returns 0x34 @0xFFFC and 0x12 @0xFFFD -> DE=0x1234, SP=0xFFFE, o_Done in cycle 6.
- CALL with PC=0x0150, WZ=0x2000, SP=0xFFFE -> writes 0x01 @0xFFFD and 0x50 @0xFFFC; SP=0xFFFC; PC=0x2000; o_Done in cycle 7. A following RET restores PC=0x0150 and SP=0xFFFE.
- Wrap: PUSH HL=0xABCD with SP=0x0000 -> writes to 0xFFFF and 0xFFFE, SP=0xFFFE. POP with SP=0xFFFF -> reads 0xFFFF and 0x0000, SP=0x0001.
- Stalls: ack delayed 3 cycles per byte and i_Enable low for 2 cycles mid-MEM_HI -> Req/Addr/Wdata held stable, no o_Write16 while disabled, o_Done delayed by exactly 8 cycles. i_Start pulsed while busy is ignored.
- Reset asserted in MEM_LO of a POP -> outputs 0 immediately; SP and destination pair are unchanged in the register file; the next start runs normally.
